spdif_sample_sched: RTL and testbench

- Scheduler/buffer between the audio sample producers and the S/PDIF encoder (`spdif_tx`).
- Buffers stereo 24-bit samples in a small FIFO and primes it before starting playback.
- Hands one sample pair to the encoder per encoder `ack` pulse.
- On underrun, substitutes silence flagged invalid and re-primes; can instead source an internal triangle test tone.

---
 rtl/spdif_sample_sched_pkg.sv | 23 ++
 rtl/spdif_sample_sched_fifo.sv | 67 ++++++
 rtl/spdif_sample_sched.sv | 158 +++++++++++++++
 tb/tb_spdif_sample_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_sample_sched_pkg.sv
// Shared constants for the S/PDIF sample scheduler: sample width,
// FSM state encodings and the test-tone packing helper.
package spdif_sample_sched_pkg;

  localparam int SAMPLE_W = 24;
  localparam int PAIR_W   = 2 * SAMPLE_W;

  // FSM state encodings, kept as plain constants so legacy tools can read them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRIME  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_STARVE = 3'd3;
  localparam logic [2:0] ST_TONE   = 3'd4;

  // The 16-bit tone accumulator sits in the middle of the 24-bit word.
  localparam int TONE_PAD_HI = 2;
  localparam int TONE_PAD_LO = 6;

  function automatic logic [SAMPLE_W-1:0] tone_pack(input logic [15:0] acc);
    return {{TONE_PAD_HI{1'b0}}, acc, {TONE_PAD_LO{1'b0}}};
  endfunction

endpackage

// File: rtl/spdif_sample_sched_fifo.sv
// Stereo sample FIFO: 48-bit entries, 2^DEPTH_LOG deep, combinational head read.
// Pointers carry one extra MSB so full and empty can be told apart.
module sample_fifo
  import spdif_sample_sched_pkg::*;
#(
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [PAIR_W-1:0]    wdata_i,
  input  logic                 pop_i,
  output logic [PAIR_W-1:0]    rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_LOG:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [PAIR_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
  logic               do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG] != rd_ptr_q[DEPTH_LOG]) &&
                   (wr_ptr_q[DEPTH_LOG-1:0] == rd_ptr_q[DEPTH_LOG-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next pointer values; a flush returns both pointers to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sample storage write port.
  // NOTE: storage has no reset; the pointers alone decide what is valid, and
  // leaving the array unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spdif_sample_sched.sv
// Scheduler between audio producers and the S/PDIF encoder: primes a FIFO,
// hands one stereo pair per encoder ack, fills underruns with invalid
// silence, and can replace the stream with an internal triangle tone.
module spdif_sample_sched
  import spdif_sample_sched_pkg::*;
#(
  parameter int DEPTH_LOG   = 4,
  parameter int PRIME_LEVEL = 8,
  parameter int TONE_STEP   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SAMPLE_W-1:0]  in_l,
  input  logic [SAMPLE_W-1:0]  in_r,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_tone,
  output logic [SAMPLE_W-1:0]  tx_l,
  output logic [SAMPLE_W-1:0]  tx_r,
  output logic                 tx_valid,
  input  logic                 tx_ack,
  output logic [DEPTH_LOG:0]   stat_level,
  output logic [15:0]          stat_underrun,
  output logic                 stat_running
);

  localparam logic [DEPTH_LOG:0] PRIME_LVL = (DEPTH_LOG + 1)'(PRIME_LEVEL);
  localparam logic [15:0]        STEP      = 16'(TONE_STEP);

  logic [2:0]          state_q, state_d;
  logic [SAMPLE_W-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic                tx_valid_q, tx_valid_d;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         underrun_q, underrun_d;

  logic                fifo_flush, fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [PAIR_W-1:0]   fifo_rdata;
  logic [DEPTH_LOG:0]  fifo_level;
  logic [15:0]         acc_next;

  assign fifo_flush = (state_q == ST_IDLE) || !ctrl_enable;
  assign in_ready   = (state_q != ST_IDLE) && !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign acc_next   = acc_q + STEP;

  sample_fifo #(
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i ({in_l, in_r}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Next-state, output-load and pop decisions for the playback FSM.
  // NOTE: combinational logic uses blocking '=' and assigns every target a
  // default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    state_d    = state_q;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    tx_valid_d = tx_valid_q;
    acc_d      = acc_q;
    underrun_d = underrun_q;
    fifo_pop   = 1'b0;

    if (!ctrl_enable) begin
      state_d    = ST_IDLE;
      tx_l_d     = '0;
      tx_r_d     = '0;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ctrl_tone ? ST_TONE : ST_PRIME;
        end
        ST_PRIME, ST_STARVE: begin
          if (fifo_level >= PRIME_LVL) begin
            // Entry into RUN loads the head; a coincident ack is absorbed.
            state_d    = ST_RUN;
            tx_l_d     = fifo_rdata[PAIR_W-1:SAMPLE_W];
            tx_r_d     = fifo_rdata[SAMPLE_W-1:0];
            tx_valid_d = 1'b1;
            fifo_pop   = 1'b1;
          end else if (tx_ack) begin
            tx_l_d     = '0;
            tx_r_d     = '0;
            tx_valid_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (tx_ack) begin
            if (!fifo_empty) begin
              tx_l_d     = fifo_rdata[PAIR_W-1:SAMPLE_W];
              tx_r_d     = fifo_rdata[SAMPLE_W-1:0];
              tx_valid_d = 1'b1;
              fifo_pop   = 1'b1;
            end else begin
              tx_l_d     = '0;
              tx_r_d     = '0;
              tx_valid_d = 1'b0;
              state_d    = ST_STARVE;
              if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
            end
          end
        end
        ST_TONE: begin
          if (!ctrl_tone) begin
            state_d = ST_PRIME;
          end else if (tx_ack) begin
            acc_d      = acc_next;
            tx_l_d     = tone_pack(acc_next);
            tx_r_d     = tone_pack(acc_next);
            tx_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, output and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      tx_valid_q <= 1'b0;
      acc_q      <= '0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      tx_valid_q <= tx_valid_d;
      acc_q      <= acc_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_l          = tx_l_q;
  assign tx_r          = tx_r_q;
  assign tx_valid      = tx_valid_q;
  assign stat_level    = fifo_level;
  assign stat_underrun = underrun_q;
  assign stat_running  = (state_q == ST_RUN) || (state_q == ST_TONE);

endmodule

// File: tb/tb_spdif_sample_sched.sv
// Self-checking bench for spdif_sample_sched: a pair queue models the FIFO
// contents, expected encoder words are queued when stimulus is driven and
// compared once the DUT has updated its registered outputs.
module tb_spdif_sample_sched;

  logic        clk;
  logic        rst;
  logic [23:0] in_l, in_r;
  logic        in_valid;
  logic        in_ready;
  logic        ctrl_enable, ctrl_tone;
  logic [23:0] tx_l, tx_r;
  logic        tx_valid;
  logic        tx_ack;
  logic [4:0]  stat_level;
  logic [15:0] stat_underrun;
  logic        stat_running;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        v;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] mdl_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          nv = 0;
  logic [15:0] tacc = 16'd0;
  logic [23:0] last_tone;

  spdif_sample_sched #(
    .DEPTH_LOG   (4),
    .PRIME_LEVEL (8),
    .TONE_STEP   (1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_l          (in_l),
    .in_r          (in_r),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ctrl_enable   (ctrl_enable),
    .ctrl_tone     (ctrl_tone),
    .tx_l          (tx_l),
    .tx_r          (tx_r),
    .tx_valid      (tx_valid),
    .tx_ack        (tx_ack),
    .stat_level    (stat_level),
    .stat_underrun (stat_underrun),
    .stat_running  (stat_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Advance one full cycle; inputs change and outputs are sampled on negedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic compare_tx(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_l"}, 32'(tx_l), 32'(e.l));
      check({tag, "_r"}, 32'(tx_r), 32'(e.r));
      check({tag, "_v"}, 32'(tx_valid), 32'(e.v));
    end
  endtask

  task automatic do_push();
    check("push_ready", 32'(in_ready), 32'd1);
    in_l     = 24'(nv);
    in_r     = 24'(nv + 100);
    in_valid = 1'b1;
    mdl_q.push_back({24'(nv), 24'(nv + 100)});
    nv++;
    step();
    in_valid = 1'b0;
  endtask

  // Expected load of the FIFO head on entry to RUN.
  task automatic expect_head();
    logic [47:0] p;
    exp_t        e;
    if (mdl_q.size() == 0) begin
      check("head_model_empty", 32'd1, 32'd0);
    end else begin
      p   = mdl_q.pop_front();
      e.l = p[47:24];
      e.r = p[23:0];
      e.v = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_ack_run(input bit with_push);
    logic [47:0] p;
    exp_t        e;
    if (mdl_q.size() > 0) begin
      p   = mdl_q.pop_front();
      e.l = p[47:24];
      e.r = p[23:0];
      e.v = 1'b1;
    end else begin
      e.l = '0;
      e.r = '0;
      e.v = 1'b0;
    end
    exp_q.push_back(e);
    tx_ack = 1'b1;
    if (with_push) begin
      in_l     = 24'(nv);
      in_r     = 24'(nv + 100);
      in_valid = 1'b1;
      mdl_q.push_back({24'(nv), 24'(nv + 100)});
      nv++;
    end
    step();
    tx_ack   = 1'b0;
    in_valid = 1'b0;
    compare_tx("run_ack");
  endtask

  task automatic do_ack_tone();
    exp_t e;
    tacc      = tacc + 16'd1024;
    last_tone = {2'b00, tacc, 6'b000000};
    e.l = last_tone;
    e.r = last_tone;
    e.v = 1'b1;
    exp_q.push_back(e);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    compare_tx("tone_ack");
  endtask

  initial begin
    rst         = 1'b1;
    in_l        = '0;
    in_r        = '0;
    in_valid    = 1'b0;
    ctrl_enable = 1'b0;
    ctrl_tone   = 1'b0;
    tx_ack      = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset state.
    check("rst_tx_l", 32'(tx_l), 32'd0);
    check("rst_tx_r", 32'(tx_r), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_level", 32'(stat_level), 32'd0);
    check("rst_underrun", 32'(stat_underrun), 32'd0);
    check("rst_running", 32'(stat_running), 32'd0);

    // Prime: 8 pushes, then RUN loads pair 0.
    ctrl_enable = 1'b1;
    step();
    check("prime_running", 32'(stat_running), 32'd0);
    for (int i = 0; i < 8; i++) do_push();
    check("prime_level8", 32'(stat_level), 32'd8);
    expect_head();
    step();
    compare_tx("run_entry");
    check("run_level7", 32'(stat_level), 32'd7);
    check("run_running", 32'(stat_running), 32'd1);

    // Steady state: one push per ack, widely spaced acks.
    for (int k = 0; k < 6; k++) begin
      repeat (511) step();
      do_ack_run(1'b1);
    end
    check("steady_level", 32'(stat_level), 32'd7);
    check("steady_underrun", 32'(stat_underrun), 32'd0);

    // Underrun: drain, then one more ack gives invalid silence.
    for (int k = 0; k < 7; k++) do_ack_run(1'b0);
    do_ack_run(1'b0);
    check("starve_underrun", 32'(stat_underrun), 32'd1);
    check("starve_running", 32'(stat_running), 32'd0);
    for (int i = 0; i < 8; i++) do_push();
    expect_head();
    step();
    compare_tx("resume_entry");
    check("resume_running", 32'(stat_running), 32'd1);

    // Push into an empty FIFO on the same cycle as an ack is still an underrun.
    for (int k = 0; k < 7; k++) do_ack_run(1'b0);
    do_ack_run(1'b1);
    check("nobypass_underrun", 32'(stat_underrun), 32'd2);
    check("nobypass_level", 32'(stat_level), 32'd1);
    for (int i = 0; i < 7; i++) do_push();
    expect_head();
    step();
    compare_tx("resume2_entry");
    do_ack_run(1'b0);
    do_ack_run(1'b0);
    check("predis_level", 32'(stat_level), 32'd5);

    // Disable mid-stream.
    ctrl_enable = 1'b0;
    step();
    mdl_q.delete();
    check("dis_level", 32'(stat_level), 32'd0);
    check("dis_tx_valid", 32'(tx_valid), 32'd0);
    check("dis_tx_l", 32'(tx_l), 32'd0);
    check("dis_running", 32'(stat_running), 32'd0);
    check("dis_in_ready", 32'(in_ready), 32'd0);
    check("dis_underrun", 32'(stat_underrun), 32'd2);

    // Tone: three acks.
    ctrl_tone   = 1'b1;
    ctrl_enable = 1'b1;
    step();
    check("tone_running", 32'(stat_running), 32'd1);
    for (int k = 0; k < 3; k++) do_ack_tone();
    check("tone_third", 32'(tx_l), 32'h030000);

    // Full: 16 pushes while in TONE, then a 17th offer is refused.
    for (int i = 0; i < 16; i++) do_push();
    check("full_level", 32'(stat_level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_l     = 24'hABCDEF;
    in_r     = 24'h123456;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("full_level_hold", 32'(stat_level), 32'd16);

    // Leave TONE: PRIME keeps the tone word, then RUN loads the FIFO head.
    ctrl_tone = 1'b0;
    step();
    check("tone_exit_hold", 32'(tx_l), 32'(last_tone));
    expect_head();
    step();
    compare_tx("tone_to_run");
    check("tone_to_run_level", 32'(stat_level), 32'd15);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx_l", 32'(tx_l), 32'd0);
    check("arst_tx_r", 32'(tx_r), 32'd0);
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    check("arst_level", 32'(stat_level), 32'd0);
    check("arst_underrun", 32'(stat_underrun), 32'd0);
    check("arst_running", 32'(stat_running), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
